// File: rtl/conv32_8.sv
// ============================================================================
// Module   : conv32_8
// Purpose  : Word-to-byte serializer. Accepts a 32-bit word and emits it as
//            four consecutive registered bytes in the clk_4f domain. Defining
//            CONV32_8_OVERRUN_EN adds a sticky overrun flag output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv32_8 #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out
`ifdef CONV32_8_OVERRUN_EN
  ,
  output logic        overrun
`endif
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;
  logic [7:0]  r_data;
  logic        r_out;

  logic [7:0]  w_first;
  logic [23:0] w_rest;
  logic [7:0]  w_next;
  logic [23:0] w_shifted;

  // Byte ordering is fixed at elaboration; the shift register always drains
  // from the end that holds the next byte to send.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_first   = in_data[31:24];
      assign w_rest    = in_data[23:0];
      assign w_next    = r_shift[23:16];
      assign w_shifted = {r_shift[15:0], 8'h00};
    end else begin : g_lsb_first
      assign w_first   = in_data[7:0];
      assign w_rest    = in_data[31:8];
      assign w_next    = r_shift[7:0];
      assign w_shifted = {8'h00, r_shift[23:8]};
    end
  endgenerate

  assign in_ready = (r_cnt == 2'd0);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'h000000;
      r_data  <= 8'h00;
      r_out   <= 1'b0;
    end else if (r_cnt != 2'd0) begin
      r_data  <= w_next;
      r_out   <= 1'b1;
      r_cnt   <= r_cnt - 2'd1;
      r_shift <= w_shifted;
    end else if (in) begin
      r_data  <= w_first;
      r_out   <= 1'b1;
      r_cnt   <= 2'd3;
      r_shift <= w_rest;
    end else begin
      r_data  <= 8'h00;
      r_out   <= 1'b0;
    end
  end

  assign out_data = r_data;
  assign out      = r_out;

`ifdef CONV32_8_OVERRUN_EN
  logic r_overrun;

  // Sticky until reset: records any word offered while busy.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (in && !in_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv32_8.sv
// ============================================================================
// Module   : tb_conv32_8
// Purpose  : Self-checking bench for conv32_8 (both byte orders) against a
//            queue-based byte-stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv32_8;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] in_data = 32'h0;
  logic        in      = 1'b0;

  logic        in_ready_m, out_m, in_ready_l, out_l;
  logic [7:0]  out_data_m, out_data_l;
`ifdef CONV32_8_OVERRUN_EN
  logic        overrun_m, overrun_l;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_4f = ~clk_4f;

  conv32_8 #(.MSB_FIRST(1)) dut_msb (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .in_data  (in_data),
    .in       (in),
    .in_ready (in_ready_m),
    .out_data (out_data_m),
    .out      (out_m)
`ifdef CONV32_8_OVERRUN_EN
    ,
    .overrun  (overrun_m)
`endif
  );

  conv32_8 #(.MSB_FIRST(0)) dut_lsb (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .in_data  (in_data),
    .in       (in),
    .in_ready (in_ready_l),
    .out_data (out_data_l),
    .out      (out_l)
`ifdef CONV32_8_OVERRUN_EN
    ,
    .overrun  (overrun_l)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word accepted on an edge becomes four bytes on the following
  // four edges; the queue holds bytes not yet presented.
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic       exp_out  = 1'b0;
  logic [7:0] exp_dm   = 8'h00;
  logic [7:0] exp_dl   = 8'h00;
  logic       exp_ovr  = 1'b0;
  logic       chk_en   = 1'b0;

  always @(posedge clk_4f) begin
    if (reset) begin
      q_m.delete();
      q_l.delete();
      exp_out = 1'b0;
      exp_dm  = 8'h00;
      exp_dl  = 8'h00;
      exp_ovr = 1'b0;
      chk_en  = 1'b1;
    end else begin
      if (in && q_m.size() != 0) exp_ovr = 1'b1;
      if (q_m.size() != 0) begin
        exp_out = 1'b1;
        exp_dm  = q_m.pop_front();
        exp_dl  = q_l.pop_front();
      end else if (in) begin
        exp_out = 1'b1;
        exp_dm  = in_data[31:24];
        exp_dl  = in_data[7:0];
        q_m = '{in_data[23:16], in_data[15:8], in_data[7:0]};
        q_l = '{in_data[15:8], in_data[23:16], in_data[31:24]};
      end else begin
        exp_out = 1'b0;
        exp_dm  = 8'h00;
        exp_dl  = 8'h00;
      end
    end
  end

  always @(negedge clk_4f) begin
    if (chk_en) begin
      chk("out_msb",      {63'h0, out_m},      {63'h0, exp_out});
      chk("out_lsb",      {63'h0, out_l},      {63'h0, exp_out});
      chk("data_msb",     {56'h0, out_data_m}, {56'h0, exp_dm});
      chk("data_lsb",     {56'h0, out_data_l}, {56'h0, exp_dl});
      chk("in_ready_msb", {63'h0, in_ready_m}, {63'h0, q_m.size() == 0});
      chk("in_ready_lsb", {63'h0, in_ready_l}, {63'h0, q_l.size() == 0});
`ifdef CONV32_8_OVERRUN_EN
      chk("overrun_msb",  {63'h0, overrun_m},  {63'h0, exp_ovr});
      chk("overrun_lsb",  {63'h0, overrun_l},  {63'h0, exp_ovr});
`endif
    end
  end

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  logic [63:0] got_m, got_l;
  logic        all_out;

  initial begin
    // Reset held three cycles, then idle.
    reset = 1'b1; in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("idle_out", {63'h0, out_m}, 64'h0);
      chk("idle_ready", {63'h0, in_ready_m}, 64'h1);
    end

    // Single word, both orders.
    in_data = 32'hA1B2C3D4; in = 1'b1;
    step();
    in = 1'b0;
    got_m = '0; got_l = '0; all_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_m = {got_m[55:0], out_data_m};
      got_l = {got_l[55:0], out_data_l};
      all_out &= out_m & out_l;
      step();
    end
    chk("single_msb", got_m, 64'hA1B2C3D4);
    chk("single_lsb", got_l, 64'hD4C3B2A1);
    chk("single_out", {63'h0, all_out}, 64'h1);
    chk("single_end", {55'h0, out_m, out_data_m}, 64'h0);

    // Back-to-back words.
    in_data = 32'h11223344; in = 1'b1;
    step();
    got_m = '0; got_l = '0; all_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got_m = {got_m[55:0], out_data_m};
      got_l = {got_l[55:0], out_data_l};
      all_out &= out_m & out_l;
      if (i == 3) in_data = 32'h55667788;
      if (i == 4) in = 1'b0;
      step();
    end
    chk("b2b_msb", got_m, 64'h1122334455667788);
    chk("b2b_lsb", got_l, 64'h4433221188776655);
    chk("b2b_out", {63'h0, all_out}, 64'h1);

    // in held with in_data changing while busy.
    in_data = 32'hCAFEBABE; in = 1'b1;
    step();
    got_m = '0;
    for (int i = 0; i < 8; i++) begin
      got_m = {got_m[55:0], out_data_m};
      if (i < 3) in_data = $urandom;
      if (i == 3) in_data = 32'h0BADF00D;
      if (i == 4) in = 1'b0;
      step();
    end
    chk("hold_msb", got_m, 64'hCAFEBABE0BADF00D);

    // Reset while B2 is on the output.
    in_data = 32'hA1B2C3D4; in = 1'b1;
    step();
    in = 1'b0;
    step();
    chk("mid_b2", {56'h0, out_data_m}, 64'hB2);
    reset = 1'b1;
    step();
    chk("mid_rst_out", {63'h0, out_m}, 64'h0);
    chk("mid_rst_ready", {63'h0, in_ready_m}, 64'h1);
    reset = 1'b0;
    repeat (4) begin
      step();
      chk("mid_no_tail", {55'h0, out_m, out_data_m}, 64'h0);
    end

    // Word offered while cnt=2.
    in_data = 32'hDEADBEEF; in = 1'b1;
    step();
    in = 1'b0;
    step();
    in = 1'b1;
    step();
    in = 1'b0;
`ifdef CONV32_8_OVERRUN_EN
    repeat (6) begin
      chk("ovr_sticky", {63'h0, overrun_m}, 64'h1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ovr_clear", {63'h0, overrun_m}, 64'h0);
`else
    repeat (6) step();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      in      = ($urandom_range(0, 2) != 0);
      in_data = $urandom;
      step();
    end
    reset = 1'b0; in = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
